// File: rtl/register_file_multiport.sv
// Multi-port integer register file: N registered read ports, M write ports,
// optional hardwired-zero entry 0, optional write-to-read bypass, post-reset scrub.
module register_file_multiport #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 5,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [READ_PORTS-1:0]         read_enable,
  input  logic [READ_PORTS*DEPTH-1:0]   read_index,
  input  logic [WRITE_PORTS-1:0]        write_enable,
  input  logic [WRITE_PORTS*DEPTH-1:0]  write_index,
  input  logic [WRITE_PORTS*WIDTH-1:0]  write_data,
  output logic [READ_PORTS*WIDTH-1:0]   read_data,
  output logic                          ready,
  output logic                          write_conflict
);

  localparam int ENTRIES = 1 << DEPTH;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]             state;
  logic [DEPTH-1:0]       scrub_cnt;
  logic [WIDTH-1:0]       mem [ENTRIES];
  logic [WIDTH-1:0]       rd_val [READ_PORTS];
  logic [WRITE_PORTS-1:0] wr_live;
  logic                   conflict_nxt;

  function automatic logic is_dropped(input logic [DEPTH-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // A write is live only if enabled and not aimed at the hardwired-zero entry.
  always_comb begin
    wr_live = '0;
    for (int w = 0; w < WRITE_PORTS; w++)
      wr_live[w] = write_enable[w] && !is_dropped(write_index[w*DEPTH +: DEPTH]);
  end

  always_comb begin
    conflict_nxt = 1'b0;
    for (int a = 0; a < WRITE_PORTS; a++)
      for (int b = 0; b < WRITE_PORTS; b++)
        if ((b > a) && wr_live[a] && wr_live[b] &&
            (write_index[a*DEPTH +: DEPTH] == write_index[b*DEPTH +: DEPTH]))
          conflict_nxt = 1'b1;
  end

  // Ascending port loop lets the highest-numbered matching writer win the bypass.
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_val[p] = mem[read_index[p*DEPTH +: DEPTH]];
      if (BYPASS != 0)
        for (int w = 0; w < WRITE_PORTS; w++)
          if (wr_live[w] && (write_index[w*DEPTH +: DEPTH] == read_index[p*DEPTH +: DEPTH]))
            rd_val[p] = write_data[w*WIDTH +: WIDTH];
      if (is_dropped(read_index[p*DEPTH +: DEPTH]))
        rd_val[p] = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state          <= CLEAR;
      scrub_cnt      <= '0;
      write_conflict <= 1'b0;
      read_data      <= '0;
    end else if (state == CLEAR) begin
      scrub_cnt      <= scrub_cnt + 1'b1;
      write_conflict <= 1'b0;
      read_data      <= '0;
      if (scrub_cnt == DEPTH'(ENTRIES - 1))
        state <= RUN;
    end else begin
      write_conflict <= conflict_nxt;
      for (int p = 0; p < READ_PORTS; p++)
        if (read_enable[p])
          read_data[p*WIDTH +: WIDTH] <= rd_val[p];
    end
  end

  // Storage is not reset; the scrub walks every entry to zero instead.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      if (state == CLEAR)
        mem[scrub_cnt] <= '0;
      else
        for (int w = 0; w < WRITE_PORTS; w++)
          if (wr_live[w])
            mem[write_index[w*DEPTH +: DEPTH]] <= write_data[w*WIDTH +: WIDTH];
    end
  end

  assign ready = (state == RUN);

endmodule

// File: doc/register_file_multiport.md
Name: register_file_multiport

Overview:
Parametrised multi-port integer register file; successor to the single-write/dual-read register file. Supports configurable read and write port counts, optional hardwired-zero register 0, and write-to-read bypass. Runs a post-reset scrub that clears every entry and reports readiness. Sits between decode (read indices) and writeback (one write port per retiring lane) in the core pipeline.

Parameters:
WIDTH, 32, data width of each register
DEPTH, 5, index width in bits; entry count = 2^DEPTH
READ_PORTS, 2, number of read ports (1..4)
WRITE_PORTS, 2, number of write ports (1..2)
ZERO_REG, 1, 1 = entry 0 is hardwired zero (writes ignored, reads return 0)
BYPASS, 1, 1 = same-cycle write data is forwarded to a matching read

Ports:
CLK  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
read_enable  input  READ_PORTS  per-port read strobe
read_index  input  READ_PORTS*DEPTH  port p at bits [p*DEPTH +: DEPTH]
write_enable  input  WRITE_PORTS  per-port write strobe
write_index  input  WRITE_PORTS*DEPTH  port w at bits [w*DEPTH +: DEPTH]
write_data  input  WRITE_PORTS*WIDTH  port w at bits [w*WIDTH +: WIDTH]
read_data  output  READ_PORTS*WIDTH  registered read result, port p at [p*WIDTH +: WIDTH]
ready  output  1  1 = scrub complete, file accepts reads/writes
write_conflict  output  1  registered flag: previous cycle had two enabled writes to the same effective index

Behaviour:
- One clock, CLK; reset synchronous, active-high, sampled on rising edge.
- FSM states: CLEAR, RUN. Reset value: state=CLEAR, scrub counter=0, ready=0, write_conflict=0, all read_data=0.
- CLEAR: while reset high, counter holds 0 and nothing is written. Each edge with reset low writes 0 to entry[counter] and increments the counter.
- CLEAR exit: the edge that clears entry 2^DEPTH-1 moves state to RUN and sets ready=1. With DEPTH=5, ready rises on the 32nd edge after reset deasserts.
- In CLEAR: write_enable ignored, read_data forced to 0, write_conflict held 0.
- Reset asserted in RUN or mid-CLEAR: next edge returns to CLEAR, counter=0, ready=0, read_data=0. Entry contents are not trusted until ready rises again.
- RUN write:
  - write_enable[w]=1 writes write_data[w] to entry[write_index[w]] at the edge.
  - With ZERO_REG=1, writes to index 0 are dropped.
  - Same index on two enabled ports: the higher-numbered port wins.
  - write_conflict=1 for exactly the following cycle. A conflict on index 0 with ZERO_REG=1 does not set it.
- RUN read (latency 1):
  - read_enable[p]=1 at edge N: read_data[p] shows the entry value from edge N onward.
  - read_enable[p]=0: read_data[p] holds its previous value (no tri-state).
  - Index 0 with ZERO_REG=1 reads 0.
- Bypass:
  - BYPASS=1: if an enabled write port in the same cycle targets the read index (and it is not the dropped index 0), read_data gets that write_data; the highest-numbered matching port wins.
  - BYPASS=0: read_data gets the pre-write entry value.
- Any read port may read any index concurrently, including duplicate indices across ports.
- No X propagation: every entry has a defined value once ready=1.

Test Plan:
1. Scrub: deassert reset, write_enable ignored during CLEAR -> ready=0 for 31 edges, ready=1 at edge 32 (DEPTH=5); subsequent read of every index returns 0x00000000.
2. Basic write/read: write port0 idx 5 = 0xDEADBEEF; next cycle read port1 idx 5 -> read_data port1 = 0xDEADBEEF one edge later; hold read_enable=0 -> value stays 0xDEADBEEF while idx changes.
3. Zero register: write idx 0 = 0x12345678 (ZERO_REG=1) -> read idx 0 returns 0. Same test with ZERO_REG=0 returns 0x12345678.
4. Conflict: port0 and port1 both write idx 7 (0x11111111 / 0x22222222) -> entry 7 = 0x22222222, write_conflict=1 for exactly one cycle, then 0.
5. Bypass: same cycle write idx 9 = 0xA5A5A5A5 and read idx 9 (old value 0) -> BYPASS=1: read_data=0xA5A5A5A5; BYPASS=0: read_data=0, next read=0xA5A5A5A5.
6. Reset mid-operation: write idx 3 = 0xCAFEF00D, assert reset for 1 cycle at scrub count 10 of a second scrub -> ready drops, read_data=0, ready rises 32 edges after release, idx 3 reads 0.
